// File: rtl/uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_frame_ctrl
// Brief   : Assembles length-prefixed command frames from the UART receiver
//           byte stream. The frame format is SYNC, LEN, payload, and an
//           optional XOR checksum. Each frame is checked and buffered. Its
//           payload is released on a valid/ready byte stream only after the
//           whole frame has been accepted.
// Config  : define UART_FRAME_CHKSUM_EN to add the trailing checksum byte
//           (CHK state, chk register, error code 2'b10).
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_frame_ctrl #(
  parameter int         MaxPayload   = 16,
  parameter logic [7:0] SyncByte     = 8'hA5,
  parameter int         TimeoutTicks = 640
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sample_tick_i,
  input  logic        rx_done_tick_i,
  input  logic [7:0]  rx_data_i,
  output logic [7:0]  m_data_o,
  output logic        m_valid_o,
  output logic        m_last_o,
  input  logic        m_ready_i,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic [15:0] frame_cnt_o
);

  localparam int c_IDX_W = $clog2(MaxPayload + 1);
  localparam int c_PTR_W = (MaxPayload > 1) ? $clog2(MaxPayload) : 1;
  localparam int c_TMO_W = $clog2(TimeoutTicks);

  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TimeoutTicks - 1);
  localparam logic [7:0]         c_MAX_LEN  = 8'(MaxPayload);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

  localparam logic [1:0] c_ERR_OVERRUN = 2'b00;
  localparam logic [1:0] c_ERR_BADLEN  = 2'b01;
`ifdef UART_FRAME_CHKSUM_EN
  localparam logic [1:0] c_ERR_CHKSUM  = 2'b10;
`endif
  localparam logic [1:0] c_ERR_TIMEOUT = 2'b11;

`ifdef UART_FRAME_CHKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_DRAIN   = 3'd4
  } state_t;
`endif

  state_t             r_state;
  logic [c_IDX_W-1:0] r_len;
  logic [c_IDX_W-1:0] r_wr_idx;
  logic [c_IDX_W-1:0] r_rd_idx;
  logic [c_TMO_W-1:0] r_tmo_cnt;
  logic [7:0]         r_buf [MaxPayload];
`ifdef UART_FRAME_CHKSUM_EN
  logic [7:0]         r_chk;
`endif

  logic               w_timed;
  logic               w_tmo_fire;
  logic               w_buf_we;
  logic [c_IDX_W-1:0] w_len_m1;
  logic [c_IDX_W-1:0] w_rd_next;
  logic [c_PTR_W-1:0] w_wr_ptr;
  logic [c_PTR_W-1:0] w_rd_ptr_next;
  logic [7:0]         w_first_byte;
  logic               w_first_last;

  // Timeout qualification, buffer addressing, and the first drain byte.
  always_comb begin
`ifdef UART_FRAME_CHKSUM_EN
    w_timed = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) || (r_state == ST_CHK);
`else
    w_timed = (r_state == ST_LEN) || (r_state == ST_PAYLOAD);
`endif
    // A byte in the same cycle as the final tick wins over the timeout.
    w_tmo_fire    = w_timed && sample_tick_i && !rx_done_tick_i && (r_tmo_cnt == c_TMO_LAST);
    w_buf_we      = (r_state == ST_PAYLOAD) && rx_done_tick_i;
    w_len_m1      = r_len - c_IDX_ONE;
    w_rd_next     = r_rd_idx + c_IDX_ONE;
    w_wr_ptr      = r_wr_idx[c_PTR_W-1:0];
    w_rd_ptr_next = w_rd_next[c_PTR_W-1:0];
    // With a one-byte payload and no checksum, byte 0 is still being written
    // in the cycle that starts the drain, so it is taken directly from the input.
    w_first_byte  = (r_wr_idx == '0) ? rx_data_i : r_buf[0];
    w_first_last  = (r_len == c_IDX_ONE);
  end

  // Payload buffer write port. The contents are only read after they are written, so the buffer has no reset.
  always_ff @(posedge clk_i) begin
    if (w_buf_we) begin
      r_buf[w_wr_ptr] <= rx_data_i;
    end
  end

  // Frame state machine, timeout counter and registered stream/error outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
      r_tmo_cnt   <= '0;
`ifdef UART_FRAME_CHKSUM_EN
      r_chk       <= '0;
`endif
      m_data_o    <= '0;
      m_valid_o   <= 1'b0;
      m_last_o    <= 1'b0;
      err_o       <= 1'b0;
      err_code_o  <= '0;
      frame_cnt_o <= '0;
    end else begin
      err_o <= 1'b0;

      // Every byte clears the counter, and every timed state is entered on a byte.
      if (rx_done_tick_i) begin
        r_tmo_cnt <= '0;
      end else if (w_timed && sample_tick_i) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end

      if (w_tmo_fire) begin
        err_o      <= 1'b1;
        err_code_o <= c_ERR_TIMEOUT;
        r_state    <= ST_IDLE;
        r_tmo_cnt  <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (rx_done_tick_i && (rx_data_i == SyncByte)) begin
              r_state <= ST_LEN;
            end
          end

          ST_LEN: begin
            if (rx_done_tick_i) begin
              if ((rx_data_i == 8'h00) || (rx_data_i > c_MAX_LEN)) begin
                err_o      <= 1'b1;
                err_code_o <= c_ERR_BADLEN;
                r_state    <= ST_IDLE;
              end else begin
                r_len    <= rx_data_i[c_IDX_W-1:0];
                r_wr_idx <= '0;
`ifdef UART_FRAME_CHKSUM_EN
                r_chk    <= rx_data_i;
`endif
                r_state  <= ST_PAYLOAD;
              end
            end
          end

          ST_PAYLOAD: begin
            if (rx_done_tick_i) begin
              r_wr_idx <= r_wr_idx + c_IDX_ONE;
`ifdef UART_FRAME_CHKSUM_EN
              r_chk    <= r_chk ^ rx_data_i;
              if (r_wr_idx == w_len_m1) begin
                r_state <= ST_CHK;
              end
`else
              if (r_wr_idx == w_len_m1) begin
                r_state   <= ST_DRAIN;
                r_rd_idx  <= '0;
                m_valid_o <= 1'b1;
                m_data_o  <= w_first_byte;
                m_last_o  <= w_first_last;
              end
`endif
            end
          end

`ifdef UART_FRAME_CHKSUM_EN
          ST_CHK: begin
            if (rx_done_tick_i) begin
              if (rx_data_i == r_chk) begin
                r_state   <= ST_DRAIN;
                r_rd_idx  <= '0;
                m_valid_o <= 1'b1;
                m_data_o  <= w_first_byte;
                m_last_o  <= w_first_last;
              end else begin
                err_o      <= 1'b1;
                err_code_o <= c_ERR_CHKSUM;
                r_state    <= ST_IDLE;
              end
            end
          end
`endif

          ST_DRAIN: begin
            // A byte arriving during the drain is lost and flagged. The drain itself continues.
            if (rx_done_tick_i) begin
              err_o      <= 1'b1;
              err_code_o <= c_ERR_OVERRUN;
            end
            if (m_valid_o && m_ready_i) begin
              if (m_last_o) begin
                r_state     <= ST_IDLE;
                m_valid_o   <= 1'b0;
                m_last_o    <= 1'b0;
                frame_cnt_o <= frame_cnt_o + 16'd1;
              end else begin
                r_rd_idx <= w_rd_next;
                m_data_o <= r_buf[w_rd_ptr_next];
                m_last_o <= (w_rd_next == w_len_m1);
              end
            end
          end

          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
